sha_msg_padder: RTL
===================

SHA_MSG_PADDER -- requirements
Module: sha_msg_padder

Interface
REQ-001 Parameter MSG_WORDS, default 9, number of 32-bit message words captured from seq_in; legal range 1..13.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 seq_in  input  32*MSG_WORDS  message from random-sequence generator; MSB-first, word 0 = bits [top:top-31].
REQ-005 seq_done  input  1  level; high when seq_in is valid and stable.
REQ-006 word_out  output  32  current SHA-256 message-block word.
REQ-007 word_valid  output  1  word_out valid this cycle.
REQ-008 word_ready  input  1  downstream hash core accepts word_out when word_valid and word_ready are both high.
REQ-009 word_index  output  4  index 0..15 of word_out within the 512-bit block.
REQ-010 busy  output  1  high while a block is being streamed.
REQ-011 block_done  output  1  single-cycle pulse on acceptance of word 15.

Function
REQ-012 FSM states SHALL be IDLE, STREAM and WAIT_LOW.
REQ-013 IDLE: when seq_done = 1 is sampled, SHALL capture seq_in into an internal register and go to STREAM; word_valid rises the next cycle.
REQ-014 STREAM: word_valid = 1 and busy = 1; word_index starts at 0.
REQ-015 Transfer = word_valid & word_ready; on each transfer word_index SHALL increment by 1.
REQ-016 With word_ready low, word_out and word_index SHALL hold unchanged; no wait-state limit.
REQ-017 Word map: index i < MSG_WORDS -> captured word i; i = MSG_WORDS -> 32'h80000000; MSG_WORDS < i < 15 -> 32'h00000000; i = 15 -> MSG_WORDS*32 (bit length; upper 32 bits of the 64-bit length field fall in word 14 and are zero).
REQ-018 For MSG_WORDS = 9: words 9..15 = 80000000, 0, 0, 0, 0, 0, 00000120.
REQ-019 Transfer at index 15: block_done = 1 in that same cycle (combinational on the transfer); FSM goes to WAIT_LOW next cycle, and word_valid and busy drop there.
REQ-020 WAIT_LOW: word_valid = 0; SHALL remain until seq_done = 0 is sampled, then go to IDLE; a seq_done that stays high SHALL NOT start a second block.
REQ-021 Changes on seq_in after capture SHALL NOT affect the streamed words.
REQ-022 When word_valid = 0, word_out SHALL be 32'h0 and word_index SHALL be 0.
REQ-023 Throughput with word_ready tied high: 16 words in 16 consecutive cycles.

Reset
REQ-024 With reset = 0 at a clock edge: state SHALL be IDLE; word_valid, busy and block_done = 0; word_out = 0; word_index = 0; capture register cleared.
REQ-025 Reset asserted mid-stream SHALL abort the block with no block_done; on release, the block SHALL restart from IDLE only if seq_done = 1 is sampled.

Verification
REQ-026 Reset: hold reset = 0 for 3 cycles, then release with seq_done = 0 -> all outputs 0 and word_valid stays 0.
REQ-027 Nominal: seq_in = {256'h0123...CDEF (repeating), 32'h0}, seq_done = 1, word_ready = 1 -> word_valid one cycle after capture; words 0..7 match the 256-bit pattern, word 8 = 0, word 9 = 80000000, words 10..14 = 0, word 15 = 00000120; block_done once, with word 15.
REQ-028 Backpressure: word_ready random at 50% -> each word held stable while stalled; sequence identical to REQ-027; exactly 16 transfers.
REQ-029 Re-arm: after block_done, keep seq_done = 1 for 20 cycles -> no word_valid; drop seq_done for 1 cycle, then raise it -> a new block starts.
REQ-030 Mid-stream reset: assert reset after the index-5 transfer -> next cycle word_valid = 0, word_index = 0, no block_done.
REQ-031 Capture isolation: change seq_in every cycle during STREAM -> words 0..8 equal the seq_in value at capture.

Source files
------------

// File: rtl/sha_msg_padder.sv
// Streams one padded 512-bit SHA-256 block (16 x 32-bit words) built from a captured
// MSG_WORDS-word message: message words, 0x80 marker, zero fill, then the 64-bit bit length.
module sha_msg_padder #(
  parameter int MSG_WORDS = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [32*MSG_WORDS-1:0]  seq_in,
  input  logic                     seq_done,
  output logic [31:0]              word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [3:0]               word_index,
  output logic                     busy,
  output logic                     block_done
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_LOW} state_t;

  localparam logic [31:0] BIT_LEN = 32'(MSG_WORDS * 32);

  state_t                    state_q, state_d;
  logic [32*MSG_WORDS-1:0]   msg_q, msg_d;
  logic [3:0]                idx_q, idx_d;
  logic [31:0]               block_words [16];

  // Static view of the whole padded block; only the message words come from the register.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_map
      if (gi < MSG_WORDS) begin : g_msg
        assign block_words[gi] = msg_q[32*(MSG_WORDS-gi)-1 -: 32];
      end else if (gi == MSG_WORDS) begin : g_marker
        assign block_words[gi] = 32'h8000_0000;
      end else if (gi == 15) begin : g_len
        assign block_words[gi] = BIT_LEN;
      end else begin : g_zero
        assign block_words[gi] = 32'h0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    idx_d      = idx_q;
    word_valid = 1'b0;
    busy       = 1'b0;
    block_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_done) begin
          msg_d   = seq_in;
          idx_d   = 4'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        word_valid = 1'b1;
        busy       = 1'b1;
        if (word_ready) begin
          if (idx_q == 4'd15) begin
            // A reset landing on the final transfer aborts the block, so no completion pulse.
            block_done = reset;
            idx_d      = 4'd0;
            state_d    = WAIT_LOW;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WAIT_LOW: begin
        if (!seq_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_out   = word_valid ? block_words[idx_q] : 32'h0;
  assign word_index = word_valid ? idx_q : 4'd0;

endmodule
